// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sequencing the LC3 MEM stage (req0) and the debug loader (req1)
// onto the single data-memory port. Optional BUSY timeout abort: define DMEM_ARB_TIMEOUT_EN.
module dmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
`ifdef DMEM_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_rd,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_din,
  output logic [DATA_W-1:0] req0_dout,
  output logic              req0_done,
  input  logic              req1_valid,
  input  logic              req1_rd,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_din,
  output logic [DATA_W-1:0] req1_dout,
  output logic              req1_done,
  output logic              Data_req,
  output logic              Data_rd,
  output logic [ADDR_W-1:0] Data_addr,
  output logic [DATA_W-1:0] Data_din,
  input  logic [DATA_W-1:0] Data_dout,
`ifdef DMEM_ARB_TIMEOUT_EN
  output logic              timeout_err,
`endif
  input  logic              complete_data
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                grant_q, grant_d;
  logic                req_d, rd_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   din_d, dout0_d, dout1_d, rdata;
  logic                done0_d, done1_d;
  logic                pick, finish;

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_d;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      Data_req     <= 1'b0;
      Data_rd      <= 1'b0;
      Data_addr    <= '0;
      Data_din     <= '0;
      req0_dout    <= '0;
      req1_dout    <= '0;
      req0_done    <= 1'b0;
      req1_done    <= 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      timeout_err  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      Data_req     <= req_d;
      Data_rd      <= rd_d;
      Data_addr    <= addr_d;
      Data_din     <= din_d;
      req0_dout    <= dout0_d;
      req1_dout    <= dout1_d;
      req0_done    <= done0_d;
      req1_done    <= done1_d;
`ifdef DMEM_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      timeout_err  <= err_d;
`endif
    end
  end

  // With both requesting, the one not served last wins; otherwise whoever is valid.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    req_d        = Data_req;
    rd_d         = Data_rd;
    addr_d       = Data_addr;
    din_d        = Data_din;
    dout0_d      = req0_dout;
    dout1_d      = req1_dout;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    rdata        = Data_dout;
    finish       = 1'b0;
    pick         = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
`ifdef DMEM_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = timeout_err;
`endif

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_d      = pick;
          last_grant_d = pick;
          req_d        = 1'b1;
          rd_d         = pick ? req1_rd   : req0_rd;
          addr_d       = pick ? req1_addr : req0_addr;
          din_d        = pick ? req1_din  : req0_din;
          state_d      = BUSY;
`ifdef DMEM_ARB_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end
      end
      BUSY: begin
        finish = complete_data;
`ifdef DMEM_ARB_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
        // A completion arriving on the final allowed cycle still counts as a normal finish.
        if (!complete_data && (cnt_q == CNT_W'(TIMEOUT_CYC - 1))) begin
          finish = 1'b1;
          rdata  = '1;
          err_d  = 1'b1;
        end
`endif
        if (finish) begin
          req_d   = 1'b0;
          state_d = RESP;
          if (grant_q) begin
            done1_d = 1'b1;
            if (Data_rd) dout1_d = rdata;
          end else begin
            done0_d = 1'b1;
            if (Data_rd) dout0_d = rdata;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, grant-order and timeout
// sequences, then randomized traffic against a transaction-level round-robin model.
module tb_dmem_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req0_rd, req0_done;
  logic [15:0] req0_addr, req0_din, req0_dout;
  logic        req1_valid, req1_rd, req1_done;
  logic [15:0] req1_addr, req1_din, req1_dout;
  logic        Data_req, Data_rd, complete_data;
  logic [15:0] Data_addr, Data_din, Data_dout;
`ifdef DMEM_ARB_TIMEOUT_EN
  logic        timeout_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dmem_arbiter #(
    .ADDR_W(16),
    .DATA_W(16)
`ifdef DMEM_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(8)
`endif
  ) dut (
    .clock(clock),
    .reset(reset),
    .req0_valid(req0_valid),
    .req0_rd(req0_rd),
    .req0_addr(req0_addr),
    .req0_din(req0_din),
    .req0_dout(req0_dout),
    .req0_done(req0_done),
    .req1_valid(req1_valid),
    .req1_rd(req1_rd),
    .req1_addr(req1_addr),
    .req1_din(req1_din),
    .req1_dout(req1_dout),
    .req1_done(req1_done),
    .Data_req(Data_req),
    .Data_rd(Data_rd),
    .Data_addr(Data_addr),
    .Data_din(Data_din),
    .Data_dout(Data_dout),
`ifdef DMEM_ARB_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .complete_data(complete_data)
  );

  // One row: inputs driven for a cycle, then outputs expected after that cycle's edge.
  typedef struct {
    logic rst;
    logic v0; logic rd0; logic [15:0] a0; logic [15:0] d0;
    logic v1; logic rd1; logic [15:0] a1; logic [15:0] d1;
    logic cmp; logic [15:0] mdout;
    logic ereq; logic erd; logic [15:0] eaddr; logic [15:0] edin;
    logic edone0; logic edone1; logic [15:0] edout0; logic [15:0] edout1;
  } vec_t;

  vec_t vecs[19];

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic checkFlag(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset         = v.rst;
    req0_valid    = v.v0;  req0_rd = v.rd0; req0_addr = v.a0; req0_din = v.d0;
    req1_valid    = v.v1;  req1_rd = v.rd1; req1_addr = v.a1; req1_din = v.d1;
    complete_data = v.cmp;
    Data_dout     = v.mdout;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // Randomized-phase reference state: requester transactions and arbitration history.
  logic [15:0] mem [256];
  bit          pend [2];
  logic        trd [2];
  logic [15:0] taddr [2];
  logic [15:0] tdin [2];
  logic [15:0] exp_dout [2];
  bit          inflight;
  int          owner, last_served, issue_cyc, cmp_cyc, done_cyc, free_from;
  int          exp_owner, waited;

  initial begin
    vecs[0]  = '{H, L,L,16'h0,16'h0,    L,L,16'h0,16'h0,       L,16'h0,    L,L,16'h0,16'h0,       L,L,16'h0,16'h0};
    vecs[1]  = '{L, H,H,16'h3000,16'h0, L,L,16'h0,16'h0,       L,16'h0,    H,H,16'h3000,16'h0,    L,L,16'h0,16'h0};
    vecs[2]  = '{L, H,H,16'h3000,16'h0, L,L,16'h0,16'h0,       L,16'h0,    H,H,16'h3000,16'h0,    L,L,16'h0,16'h0};
    vecs[3]  = '{L, H,H,16'h3000,16'h0, L,L,16'h0,16'h0,       L,16'h0,    H,H,16'h3000,16'h0,    L,L,16'h0,16'h0};
    vecs[4]  = '{L, H,H,16'h3000,16'h0, L,L,16'h0,16'h0,       H,16'h1234, L,H,16'h3000,16'h0,    H,L,16'h1234,16'h0};
    vecs[5]  = '{L, L,L,16'h0,16'h0,    L,L,16'h0,16'h0,       L,16'h0,    L,H,16'h3000,16'h0,    L,L,16'h1234,16'h0};
    vecs[6]  = '{L, L,L,16'h0,16'h0,    H,L,16'h4001,16'hBEEF, L,16'h0,    H,L,16'h4001,16'hBEEF, L,L,16'h1234,16'h0};
    vecs[7]  = '{L, L,L,16'h0,16'h0,    H,L,16'h4001,16'hBEEF, L,16'h0,    H,L,16'h4001,16'hBEEF, L,L,16'h1234,16'h0};
    vecs[8]  = '{L, L,L,16'h0,16'h0,    H,L,16'h4001,16'hBEEF, H,16'hDEAD, L,L,16'h4001,16'hBEEF, L,H,16'h1234,16'h0};
    vecs[9]  = '{L, L,L,16'h0,16'h0,    L,L,16'h0,16'h0,       L,16'h0,    L,L,16'h4001,16'hBEEF, L,L,16'h1234,16'h0};
    vecs[10] = '{L, L,L,16'h0,16'h0,    L,L,16'h0,16'h0,       H,16'h5555, L,L,16'h4001,16'hBEEF, L,L,16'h1234,16'h0};
    vecs[11] = '{L, H,H,16'h3002,16'h0, L,L,16'h0,16'h0,       L,16'h0,    H,H,16'h3002,16'h0,    L,L,16'h1234,16'h0};
    vecs[12] = '{L, H,H,16'h3002,16'h0, L,L,16'h0,16'h0,       H,16'h0042, L,H,16'h3002,16'h0,    H,L,16'h0042,16'h0};
    vecs[13] = '{L, L,L,16'h0,16'h0,    L,L,16'h0,16'h0,       H,16'h9999, L,H,16'h3002,16'h0,    L,L,16'h0042,16'h0};
    vecs[14] = '{L, L,L,16'h0,16'h0,    L,L,16'h0,16'h0,       L,16'h0,    L,H,16'h3002,16'h0,    L,L,16'h0042,16'h0};
    vecs[15] = '{L, L,L,16'h0,16'h0,    H,H,16'h5000,16'h1111, L,16'h0,    H,H,16'h5000,16'h1111, L,L,16'h0042,16'h0};
    vecs[16] = '{L, L,L,16'h0,16'h0,    H,H,16'h5000,16'h1111, L,16'h0,    H,H,16'h5000,16'h1111, L,L,16'h0042,16'h0};
    vecs[17] = '{H, L,L,16'h0,16'h0,    H,H,16'h5000,16'h1111, L,16'h0,    L,L,16'h0,16'h0,       L,L,16'h0,16'h0};
    vecs[18] = '{L, L,L,16'h0,16'h0,    L,L,16'h0,16'h0,       L,16'h0,    L,L,16'h0,16'h0,       L,L,16'h0,16'h0};

    applyStimulus(vecs[0]);
    nextCycle();

    $display("[TB] directed vector table");
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i]);
      nextCycle();
      checkFlag($sformatf("vec%0d_data_req", i), Data_req, vecs[i].ereq);
      checkFlag($sformatf("vec%0d_data_rd", i), Data_rd, vecs[i].erd);
      checkOutput($sformatf("vec%0d_data_addr", i), Data_addr, vecs[i].eaddr);
      checkOutput($sformatf("vec%0d_data_din", i), Data_din, vecs[i].edin);
      checkFlag($sformatf("vec%0d_done0", i), req0_done, vecs[i].edone0);
      checkFlag($sformatf("vec%0d_done1", i), req1_done, vecs[i].edone1);
      checkOutput($sformatf("vec%0d_dout0", i), req0_dout, vecs[i].edout0);
      checkOutput($sformatf("vec%0d_dout1", i), req1_dout, vecs[i].edout1);
    end

    $display("[TB] round-robin grant order with both requesters valid");
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    req0_valid = 1'b1; req0_rd = 1'b1; req0_addr = 16'h0100; req0_din = 16'h0;
    req1_valid = 1'b1; req1_rd = 1'b1; req1_addr = 16'h0200; req1_din = 16'h0;
    for (int k = 0; k < 4; k++) begin
      exp_owner = k % 2;
      waited = 0;
      while (!Data_req && waited < 10) begin
        nextCycle();
        waited++;
      end
      checkFlag($sformatf("grant%0d_issue", k), Data_req, 1'b1);
      checkOutput($sformatf("grant%0d_addr", k), Data_addr, (exp_owner == 1) ? 16'h0200 : 16'h0100);
      complete_data = 1'b1;
      Data_dout = 16'h00A0 + 16'(k);
      nextCycle();
      complete_data = 1'b0;
      checkFlag($sformatf("grant%0d_done0", k), req0_done, exp_owner == 0);
      checkFlag($sformatf("grant%0d_done1", k), req1_done, exp_owner == 1);
      checkOutput($sformatf("grant%0d_dout", k), (exp_owner == 1) ? req1_dout : req0_dout, 16'h00A0 + 16'(k));
      if (exp_owner == 0) req0_valid = 1'b0;
      else req1_valid = 1'b0;
      nextCycle();
      checkFlag($sformatf("grant%0d_idle_done0", k), req0_done, 1'b0);
      checkFlag($sformatf("grant%0d_idle_done1", k), req1_done, 1'b0);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

`ifdef DMEM_ARB_TIMEOUT_EN
    $display("[TB] timeout: completion on the limit cycle, then a real timeout");
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    req0_valid = 1'b1; req0_rd = 1'b1; req0_addr = 16'h3100;
    nextCycle();
    for (int i = 1; i <= 8; i++) begin
      checkFlag($sformatf("to_limit_req%0d", i), Data_req, 1'b1);
      if (i == 8) begin
        complete_data = 1'b1;
        Data_dout = 16'h7777;
      end
      nextCycle();
    end
    complete_data = 1'b0;
    checkFlag("to_limit_done", req0_done, 1'b1);
    checkOutput("to_limit_dout", req0_dout, 16'h7777);
    checkFlag("to_limit_err", timeout_err, 1'b0);
    req0_valid = 1'b0;
    nextCycle();
    req0_valid = 1'b1; req0_addr = 16'h3101;
    nextCycle();
    for (int i = 1; i <= 8; i++) begin
      checkFlag($sformatf("to_wait_req%0d", i), Data_req, 1'b1);
      nextCycle();
    end
    checkFlag("to_abort_req", Data_req, 1'b0);
    checkFlag("to_abort_done", req0_done, 1'b1);
    checkOutput("to_abort_dout", req0_dout, 16'hFFFF);
    checkFlag("to_abort_err", timeout_err, 1'b1);
    req0_valid = 1'b0;
    nextCycle();
    checkFlag("to_abort_done_once", req0_done, 1'b0);
    checkFlag("to_err_sticky", timeout_err, 1'b1);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    checkFlag("to_err_reset", timeout_err, 1'b0);
`endif

    $display("[TB] randomized traffic against reference model");
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    complete_data = 1'b0;
    nextCycle();
    reset = 1'b0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    exp_dout[0] = 16'h0; exp_dout[1] = 16'h0;
    inflight = 1'b0;
    owner = 0; last_served = 1;
    issue_cyc = 0; cmp_cyc = 0; done_cyc = -10; free_from = 0;

    for (int t = 0; t < 3000; t++) begin
      checkFlag("rnd_done0", req0_done, (t == done_cyc) && (owner == 0));
      checkFlag("rnd_done1", req1_done, (t == done_cyc) && (owner == 1));
      checkOutput("rnd_dout0", req0_dout, exp_dout[0]);
      checkOutput("rnd_dout1", req1_dout, exp_dout[1]);
      checkFlag("rnd_data_req", Data_req, inflight && (t >= issue_cyc));
      if (inflight && (t >= issue_cyc)) begin
        checkFlag("rnd_data_rd", Data_rd, trd[owner]);
        checkOutput("rnd_data_addr", Data_addr, taddr[owner]);
        checkOutput("rnd_data_din", Data_din, tdin[owner]);
      end

      for (int n = 0; n < 2; n++) begin
        if ((t == done_cyc) && (owner == n)) begin
          pend[n] = 1'b0;
        end else if (!pend[n] && ($urandom_range(0, 3) == 0)) begin
          pend[n]  = 1'b1;
          trd[n]   = 1'($urandom_range(0, 1));
          taddr[n] = {8'h30, 8'($urandom)};
          tdin[n]  = 16'($urandom);
        end
        if (!pend[n]) begin
          trd[n]   = 1'($urandom_range(0, 1));
          taddr[n] = 16'($urandom);
          tdin[n]  = 16'($urandom);
        end
      end
      req0_valid = pend[0]; req0_rd = trd[0]; req0_addr = taddr[0]; req0_din = tdin[0];
      req1_valid = pend[1]; req1_rd = trd[1]; req1_addr = taddr[1]; req1_din = tdin[1];

      if (!inflight && (t >= free_from) && (pend[0] || pend[1])) begin
        owner = (pend[0] && pend[1]) ? (1 - last_served) : (pend[1] ? 1 : 0);
        last_served = owner;
        inflight = 1'b1;
        issue_cyc = t + 1;
        cmp_cyc = issue_cyc + $urandom_range(0, 3);
      end

      complete_data = 1'b0;
      Data_dout = 16'($urandom);
      if (inflight && (t == cmp_cyc)) begin
        complete_data = 1'b1;
        if (trd[owner]) begin
          Data_dout = mem[taddr[owner][7:0]];
          exp_dout[owner] = mem[taddr[owner][7:0]];
        end else begin
          mem[taddr[owner][7:0]] = tdin[owner];
        end
        inflight = 1'b0;
        done_cyc = t + 1;
        free_from = t + 2;
      end else if (!(inflight && (t >= issue_cyc)) && ($urandom_range(0, 4) == 0)) begin
        complete_data = 1'b1;
      end
      nextCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
